// File: rtl/pwm_pkg.sv
// Shared constants and types for the push-button PWM generator.
`timescale 1ns/1ps
package pwm_pkg;

   localparam int CNT_W_DEF           = 8;
   localparam int STEP_DEF            = 16;
   localparam int DUTY_RESET_DEF      = 128;
   localparam int DEBOUNCE_CYCLES_DEF = 3;
   localparam int DUTY_W_DEF          = CNT_W_DEF + 1;

   typedef enum logic [1:0] {
      DUTY_HOLD = 2'd0,
      DUTY_INC  = 2'd1,
      DUTY_DEC  = 2'd2
   } duty_op_e;

endpackage

// File: rtl/pwm_button_conditioner.sv
// Raw active-low button -> 2-FF sync -> debounce down-counter -> one-clock press pulse on falling edge.
`timescale 1ns/1ps
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic press
);

   localparam int TMR_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic             level;
   logic [TMR_W-1:0] tmr;

   // tmr counts down while the synchronized value disagrees with level; any agreement reloads it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         level  <= 1'b1;
         tmr    <= TMR_LOAD;
         press  <= 1'b0;
      end else begin
         sync_1 <= btn_n;
         sync_2 <= sync_1;
         press  <= 1'b0;
         if (sync_2 == level) begin
            tmr <= TMR_LOAD;
         end else if (tmr == '0) begin
            level <= sync_2;
            tmr   <= TMR_LOAD;
            press <= ~sync_2;
         end else begin
            tmr <= tmr - 1'b1;
         end
      end
   end

endmodule

// File: rtl/pwm.sv
// Push-button PWM generator: two conditioned buttons step a saturating duty, applied at period wrap.
// Build option: define PWM_INVERT_EN for an active-low pwm_out (idle/reset level 1).
`timescale 1ns/1ps
module pwm
   import pwm_pkg::*;
#(
   parameter int CNT_W           = CNT_W_DEF,
   parameter int STEP            = STEP_DEF,
   parameter int DUTY_RESET      = DUTY_RESET_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic button_inc,
   input  logic button_dec,
   output logic pwm_out
);

   localparam int DUTY_W = CNT_W + 1;
   localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(2 ** CNT_W);
   localparam logic [DUTY_W-1:0] STEP_V   = DUTY_W'(STEP);
   localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(DUTY_RESET);

`ifdef PWM_INVERT_EN
   localparam logic PWM_IDLE = 1'b1;
`else
   localparam logic PWM_IDLE = 1'b0;
`endif

   logic              press_inc;
   logic              press_dec;
   logic [CNT_W-1:0]  cnt;
   logic [DUTY_W-1:0] duty_next;
   logic [DUTY_W-1:0] duty_active;
   logic [DUTY_W-1:0] duty_calc;
   logic [DUTY_W:0]   duty_sum;
   duty_op_e          op;
   logic              pwm_level;
   logic              pwm_d;

   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_inc (
      .clk   (clk),
      .rst   (rst),
      .btn_n (button_inc),
      .press (press_inc)
   );

   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_dec (
      .clk   (clk),
      .rst   (rst),
      .btn_n (button_dec),
      .press (press_dec)
   );

   always_comb begin
      op        = DUTY_HOLD;
      duty_sum  = {1'b0, duty_next} + {1'b0, STEP_V};
      duty_calc = duty_next;
      if (press_inc && !press_dec) begin
         op = DUTY_INC;
      end else if (press_dec && !press_inc) begin
         op = DUTY_DEC;
      end
      case (op)
         DUTY_INC: duty_calc = (duty_sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : duty_sum[DUTY_W-1:0];
         DUTY_DEC: duty_calc = (duty_next < STEP_V) ? '0 : duty_next - STEP_V;
         default:  duty_calc = duty_next;
      endcase
   end

   always_comb begin
      pwm_level = ({1'b0, cnt} < duty_active);
`ifdef PWM_INVERT_EN
      pwm_d = ~pwm_level;
`else
      pwm_d = pwm_level;
`endif
   end

   // duty_active only moves on the last count so a running period is never cut short or stretched
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt         <= '0;
         duty_next   <= DUTY_RST;
         duty_active <= DUTY_RST;
         pwm_out     <= PWM_IDLE;
      end else begin
         cnt       <= cnt + 1'b1;
         duty_next <= duty_calc;
         if (cnt == '1) begin
            duty_active <= duty_next;
         end
         pwm_out <= pwm_d;
      end
   end

endmodule

// File: tb/tb_pwm.sv
// Directed bench for pwm: a model queues the expected high count of each period, popped at period end.
`timescale 1ns/1ps
module tb_pwm;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic button_inc = 1'b1;
   logic button_dec = 1'b1;
   logic pwm_out;

`ifdef PWM_INVERT_EN
   localparam bit INV = 1'b1;
`else
   localparam bit INV = 1'b0;
`endif
   localparam logic RST_VAL = INV;

   int tests = 0;
   int fails = 0;
   int exp_q[$];
   int model_next;
   int model_active;

   pwm dut (
      .clk        (clk),
      .rst        (rst),
      .button_inc (button_inc),
      .button_dec (button_dec),
      .pwm_out    (pwm_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_bit(input string tag, input logic obs, input logic expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   // mode: 0 idle, 1 n inc presses, 2 n dec presses, 3 both together, 4 2-clock inc glitch, 5 long inc hold
   task automatic run_period(input int mode, input int n, input string tag);
      int  highs;
      int  expv;
      bit  lo;
      highs = 0;
      exp_q.push_back(INV ? 256 - model_active : model_active);
      case (mode)
         1: repeat (n) model_next = (model_next + 16 > 256) ? 256 : model_next + 16;
         2: repeat (n) model_next = (model_next < 16) ? 0 : model_next - 16;
         5: model_next = (model_next + 16 > 256) ? 256 : model_next + 16;
         default: ;
      endcase
      for (int i = 0; i < 256; i++) begin
         @(posedge clk);
         #1;
         if (pwm_out === 1'b1) highs++;
         lo = 1'b0;
         case (mode)
            1, 2, 3: lo = (i >= 10) && ((i - 10) / 12 < n) && ((i - 10) % 12 < 5);
            4:       lo = (i >= 10) && (i < 12);
            5:       lo = (i >= 10) && (i < 50);
            default: lo = 1'b0;
         endcase
         button_inc = !(lo && (mode == 1 || mode == 3 || mode == 4 || mode == 5));
         button_dec = !(lo && (mode == 2 || mode == 3));
      end
      button_inc = 1'b1;
      button_dec = 1'b1;
      expv = exp_q.pop_front();
      tests++;
      assert (highs === expv) else begin
         fails++;
         $error("FAIL %s high_count observed=%0d expected=%0d", tag, highs, expv);
      end
      model_active = model_next;
   endtask

   initial begin
      model_next   = 128;
      model_active = 128;

      repeat (5) begin
         @(posedge clk);
         #1;
         check_bit("in_reset", pwm_out, RST_VAL);
      end
      @(negedge clk);
      rst = 1'b1;

      run_period(0, 0, "reset_duty");
      run_period(1, 1, "inc_current");
      run_period(2, 1, "inc_applied");
      run_period(0, 0, "dec_applied");
      run_period(4, 0, "glitch");
      run_period(3, 1, "both_current");
      run_period(0, 0, "both_applied");
      run_period(5, 0, "long_hold_current");

      // reset in the middle of a 144-count period with a press still in the synchronizers
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (i == 95) button_inc = 1'b0;
      end
      #3;
      rst = 1'b0;
      #1;
      check_bit("reset_async", pwm_out, RST_VAL);
      button_inc = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check_bit("reset_held", pwm_out, RST_VAL);
      end
      @(negedge clk);
      rst = 1'b1;
      model_next   = 128;
      model_active = 128;

      run_period(0, 0, "after_reset");
      run_period(1, 9, "inc9_current");
      run_period(2, 17, "full_then_dec17");
      run_period(4, 0, "zero_glitch");
      run_period(0, 0, "zero_steady");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pwm.md
Name: pwm

Overview:
- Push-button-controlled PWM generator. Two active-low buttons step the duty cycle up or down; a free-running counter compares against the duty value to drive one PWM output.
- Sits between raw board buttons and an LED or driver pin, so button conditioning is done inside the block.

Parameters:
- CNT_W, 8, counter width; PWM period = 2**CNT_W clocks.
- STEP, 16, duty change per accepted button press (counts).
- DUTY_RESET, 128, duty value loaded at reset; range 0..2**CNT_W.
- DEBOUNCE_CYCLES, 3, clocks a synchronized button level must stay stable to be accepted; must be ≥1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- button_inc  input  1  raw increment button, active-low (idle 1), asynchronous to clk.
- button_dec  input  1  raw decrement button, active-low (idle 1), asynchronous to clk.
- pwm_out  output  1  PWM waveform, registered.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0), applied immediately without waiting for a clock edge:
  - cnt=0; duty_next=duty_active=DUTY_RESET; pwm_out=0.
  - Synchronizers and debounced levels = 1; press pulses = 0.
- Button path, per button:
  - 2-FF synchronizer.
  - Debounce: the debounced level takes the synchronized value only after it differs from the current debounced level for DEBOUNCE_CYCLES consecutive clocks. Any reversion restarts the count.
  - Press pulse: one-clock pulse on a 1→0 transition of the debounced level. The release (0→1) produces nothing.
- Duty update, evaluated each clock on the press pulses:
  - inc only: duty_next = min(duty_next+STEP, 2**CNT_W).
  - dec only: duty_next = max(duty_next−STEP, 0).
  - Both in the same clock: no change.
  - duty_next is CNT_W+1 bits wide, so 100% is representable. Saturate, never wrap.
- Counter: cnt is CNT_W bits, increments every clock and wraps from 2**CNT_W−1 to 0.
- Glitch-free update: duty_active <= duty_next only in the clock where cnt == 2**CNT_W−1, so the new duty applies from the next period start. A press mid-period never truncates or extends the current period.
- Output: pwm_out <= (cnt < duty_active), one-clock latency.
  - duty=0: constant 0.
  - duty=2**CNT_W: constant 1.
- Holding a button gives exactly one step; there is no auto-repeat.
- Reset mid-period: output drops to 0 at once. After release, the first period starts at cnt=0 with DUTY_RESET. Pending presses are lost.

Optional Feature:
- Macro PWM_INVERT_EN.
- Defined: pwm_out <= !(cnt < duty_active), for active-low loads; the reset value of pwm_out becomes 1.
- Undefined: the polarity described in Behaviour.
- Duty and button logic are identical in both cases.

Decomposition:
- Package pwm_pkg: default constants for CNT_W, STEP, DUTY_RESET and DEBOUNCE_CYCLES, plus the duty width localparam (CNT_W+1).
- One sub-module, button_conditioner, instantiated twice:
  - Parameter: DEBOUNCE_CYCLES.
  - Ports: clk, rst, btn_n, press.
  - Contents: synchronizer, debounce counter, falling-edge pulse.
- The top level holds the duty register, counter and comparator.

Test Plan:
- Reset: rst=0 for 5 clocks → pwm_out=0 throughout. After release, each 256-clock period has pwm_out high for exactly 128 clocks.
- Increment: hold button_inc=0 for 5 clocks, then release → exactly one step. The period after the next wrap is high for 144 clocks; the current period is unchanged.
- Decrement: after the increment above, hold button_dec=0 for 5 clocks → the following period is high for 128 clocks again.
- Saturation and bounce:
  - 9 separate inc presses from reset → duty saturates at 256, pwm_out constantly 1.
  - Then 17 dec presses → duty saturates at 0, pwm_out constantly 0.
  - A 2-clock button_inc glitch → no change.
- Simultaneous: both buttons pressed in the same clocks → duty stays 128. Under PWM_INVERT_EN, the high/low counts swap.
